// File: rtl/regop_pkg.sv
// Shared encodings for the register-file op sequencer: command kinds, ALU
// functions, register indices and the FSM state type.
package regop_pkg;

    typedef enum logic [1:0] {
        KIND_MOVE  = 2'd0,
        KIND_INC   = 2'd1,
        KIND_DEC   = 2'd2,
        KIND_PUSH2 = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_INC  = 2'd1,
        ALU_DEC  = 2'd2
    } alu_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S2   = 2'd2,
        ST_S3   = 2'd3
    } state_e;

    localparam logic [3:0] REG_X    = 4'd0;
    localparam logic [3:0] REG_Y    = 4'd1;
    localparam logic [3:0] REG_A    = 4'd2;
    localparam logic [3:0] REG_S    = 4'd3;
    localparam logic [3:0] REG_ZERO = 4'd4;
    localparam logic [3:0] REG_ONE  = 4'd5;
    localparam logic [3:0] REG_FF   = 4'd6;
    localparam logic [3:0] REG_Z    = 4'd7;
    localparam logic [3:0] REG_NMI  = 4'd8;
    localparam logic [3:0] REG_RST  = 4'd9;
    localparam logic [3:0] REG_BRK  = 4'd10;

    localparam logic [1:0] WR_S     = 2'd3;
    localparam logic [6:0] IDLE_OP  = 7'h04;
    localparam logic [3:0] MAX_SRC  = 4'd10;

    // PUSH2 never reads cmd_src, so only the other kinds can carry an illegal index.
    function automatic logic src_is_legal(input logic [1:0] kind, input logic [3:0] src);
        if (kind == KIND_PUSH2) begin
            return 1'b1;
        end else begin
            return (src <= MAX_SRC);
        end
    endfunction

endpackage

// File: rtl/regop_step_rom.sv
// Combinational step table: (kind, step, src, dst) -> (op, alu_sel, last).
// Step 0 denotes IDLE and yields the idle op.
module regop_step_rom
    import regop_pkg::*;
(
    input  logic [1:0] i_kind,
    input  logic [1:0] i_step,
    input  logic [3:0] i_src,
    input  logic [1:0] i_dst,
    output logic [6:0] o_op,
    output logic [1:0] o_alu_sel,
    output logic       o_last
);

    // Steps outside a kind's sequence report last so the FSM falls back to IDLE.
    always_comb begin
        o_op      = IDLE_OP;
        o_alu_sel = ALU_PASS;
        o_last    = 1'b0;
        if (i_step == 2'd0) begin
            o_op      = IDLE_OP;
            o_alu_sel = ALU_PASS;
            o_last    = 1'b0;
        end else begin
            case (kind_e'(i_kind))
                KIND_MOVE: begin
                    o_op      = {1'b1, i_dst, i_src};
                    o_alu_sel = ALU_PASS;
                    o_last    = 1'b1;
                end
                KIND_INC, KIND_DEC: begin
                    o_alu_sel = (kind_e'(i_kind) == KIND_INC) ? ALU_INC : ALU_DEC;
                    case (i_step)
                        2'd1: begin
                            o_op   = {1'b0, 2'b00, i_src};
                            o_last = 1'b0;
                        end
                        default: begin
                            o_op   = {1'b1, i_dst, i_src};
                            o_last = 1'b1;
                        end
                    endcase
                end
                KIND_PUSH2: begin
                    o_alu_sel = ALU_DEC;
                    case (i_step)
                        2'd1: begin
                            o_op   = {1'b0, 2'b00, REG_S};
                            o_last = 1'b0;
                        end
                        2'd2: begin
                            o_op   = {1'b1, WR_S, REG_S};
                            o_last = 1'b0;
                        end
                        default: begin
                            o_op   = {1'b1, WR_S, REG_S};
                            o_last = 1'b1;
                        end
                    endcase
                end
                default: begin
                    o_op      = IDLE_OP;
                    o_alu_sel = ALU_PASS;
                    o_last    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/regop_sequencer.sv
// Sequences MOVE/INC/DEC/PUSH2 commands into per-cycle register-file ops.
// Outputs are registered from the next-state view so step 1 appears the cycle after acceptance.
module regop_sequencer
    import regop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_kind,
    input  logic [3:0] cmd_src,
    input  logic [1:0] cmd_dst,
    output logic       cmd_ready,
    output logic [6:0] op,
    output logic [1:0] alu_sel,
    output logic       done,
    output logic       err
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_kind;
    logic [3:0] r_src;
    logic [1:0] r_dst;
    logic [6:0] r_op;
    logic [1:0] r_alu;
    logic       r_done;
    logic       r_err;

    logic       w_accept;
    logic       w_legal;
    logic [1:0] w_kind_nxt;
    logic [3:0] w_src_nxt;
    logic [1:0] w_dst_nxt;
    logic [6:0] w_rom_op;
    logic [1:0] w_rom_alu;
    logic       w_rom_last;
    logic       w_done_nxt;
    logic       w_err_nxt;

    assign cmd_ready  = (r_state == ST_IDLE);
    assign w_accept   = cmd_valid & cmd_ready & rdy;
    assign w_legal    = src_is_legal(cmd_kind, cmd_src);
    assign w_kind_nxt = w_accept ? cmd_kind : r_kind;
    assign w_src_nxt  = w_accept ? cmd_src  : r_src;
    assign w_dst_nxt  = w_accept ? cmd_dst  : r_dst;

    assign op         = r_op;
    assign alu_sel    = r_alu;
    assign done       = r_done;
    assign err        = r_err;

    regop_step_rom u_rom (
        .i_kind    (w_kind_nxt),
        .i_step    (2'(w_state_nxt)),
        .i_src     (w_src_nxt),
        .i_dst     (w_dst_nxt),
        .o_op      (w_rom_op),
        .o_alu_sel (w_rom_alu),
        .o_last    (w_rom_last)
    );

    // State register; rdy low freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: r_done marks the step currently shown as the final one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = ST_S1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_S1:   w_state_nxt = r_done ? ST_IDLE : ST_S2;
            ST_S2:   w_state_nxt = r_done ? ST_IDLE : ST_S3;
            ST_S3:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode for the upcoming cycle.
    always_comb begin
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (w_state_nxt != ST_IDLE) begin
            w_done_nxt = w_rom_last;
        end else begin
            w_done_nxt = 1'b0;
        end
        if (w_accept && !w_legal) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = 1'b0;
        end
    end

    // Latched command and registered outputs, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind <= 2'd0;
            r_src  <= 4'd0;
            r_dst  <= 2'd0;
            r_op   <= IDLE_OP;
            r_alu  <= ALU_PASS;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (rdy) begin
            r_kind <= w_kind_nxt;
            r_src  <= w_src_nxt;
            r_dst  <= w_dst_nxt;
            r_op   <= w_rom_op;
            r_alu  <= w_rom_alu;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

endmodule

// File: doc/regop_sequencer.md
REGOP_SEQUENCER -- requirements
Module: regop_sequencer

Interface
REQ-001 Parameter: none; all encodings are fixed constants in regop_pkg.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rdy  input  1  global stall; low freezes all state and outputs.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_kind  input  2  0=MOVE, 1=INC, 2=DEC, 3=PUSH2.
REQ-007 cmd_src  input  4  register-file read index, legal 0..10.
REQ-008 cmd_dst  input  2  register-file write index: 0=X, 1=Y, 2=A, 3=S.
REQ-009 cmd_ready  output  1  high exactly when in IDLE.
REQ-010 op  output  7  register-file op: bit6=write enable, bits5:4=write index, bits3:0=read index.
REQ-011 alu_sel  output  2  ALU function between register-file DO and DI: 0=PASS, 1=INC, 2=DEC.
REQ-012 done  output  1  one-cycle pulse on the final step of a command.
REQ-013 err  output  1  one-cycle pulse when an illegal command is accepted.

Function
REQ-014 States: IDLE, S1, S2, S3.
REQ-015 Acceptance: a command is accepted when cmd_valid, cmd_ready and rdy are all high; the command fields are latched on that edge.
REQ-016 IDLE outputs: op=7'h04 (read the zero register, no write), alu_sel=PASS, done=0.
REQ-017 Latency: the first step of a command appears in the cycle after acceptance.
REQ-018 MOVE (1 step): S1 op={1,dst,src}, alu_sel=PASS, done=1; then IDLE.
REQ-019 INC/DEC (2 steps): S1 op={0,00,src}, alu_sel=INC/DEC; S2 op={1,dst,src}, same alu_sel, done=1; then IDLE.
REQ-020 PUSH2 (3 steps, cmd_src and cmd_dst ignored): S1 op=7'h03; S2 op=7'h73; S3 op=7'h73, done=1; alu_sel=DEC in all three steps; then IDLE.
REQ-021 Illegal source: cmd_src 11..15 with kind MOVE/INC/DEC is still accepted, but produces err=1 in the next cycle and stays in IDLE.
REQ-022 Illegal-source outputs: no write op is issued and done is not pulsed.
REQ-023 Stall: while rdy=0, state, latched command, op, alu_sel, done and err hold their values.
REQ-024 Stall completion: a held done/err pulse completes only on a cycle with rdy=1 and is counted once.
REQ-025 Back-to-back commands: cmd_ready is low during S1..S3; the minimum spacing between accepted commands is (steps+1) cycles.
REQ-026 cmd_valid high while not in IDLE has no effect.
REQ-027 op bit6 is never high in IDLE.
REQ-028 op bit6 is never high in the first step of INC/DEC.

Reset
REQ-029 While rst_n=0: state=IDLE, op=7'h04, alu_sel=PASS, done=0, err=0, latched command=0.
REQ-030 Reset asserted mid-command aborts the command immediately, with no further write op and no done pulse.
REQ-031 After rst_n deasserts, the first acceptance is possible on the first rising edge.

Structure
REQ-032 regop_pkg holds: kind encodings, alu_sel encodings, register indices (X=0, Y=1, A=2, S=3, ZERO=4, ONE=5, FF=6, Z=7, NMI=8, RST=9, BRK=10), IDLE_OP=7'h04 and MAX_SRC=10.
REQ-033 One sub-module, regop_step_rom: purely combinational; maps (kind, step, src, dst) to (op, alu_sel, last).
REQ-034 The FSM and latch logic stay in regop_sequencer.

Verification
REQ-035 MOVE src=2 dst=0 accepted at cycle 0 -> cycle 1 op=7'h42, alu=PASS, done=1; cycle 2 op=7'h04, cmd_ready=1.
REQ-036 INC src=0 dst=0 -> op=7'h00 then 7'h40, alu=INC both cycles, done only on the second.
REQ-037 PUSH2 -> op=7'h03, 7'h73, 7'h73, alu=DEC, done on the third; cmd_ready low for exactly 3 cycles.
REQ-038 DEC src=1 dst=1 with rdy=0 for 4 cycles during S1 -> op=7'h01 held for 5 cycles, then 7'h51 with done=1 once.
REQ-039 MOVE src=12 -> err=1 for one cycle, op stays 7'h04, done never asserted.
REQ-040 rst_n=0 during S2 of PUSH2 -> op=7'h04 asynchronously, no done; after release, MOVE src=5 dst=2 gives op=7'h65.
